// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out transmitter: FSM encoding and gap counter width.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int GAP_CW = 4;

endpackage

// File: rtl/piso_serializer.sv
// Parallel word in over valid/ready, one registered bit per clock out; first bit the cycle after accept.
// load_ready is a function of state/counter only; back-to-back words without bubble when GAP_CYCLES==0.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(WIDTH - 2);
  // The IDLE cycle that re-accepts counts as the final idle cycle, so GAP lasts GAP_CYCLES-1.
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_CW-1:0]  gap_cnt_q, gap_cnt_d;
  logic               sdo_q, sdo_d;
  logic               sdo_valid_q, sdo_valid_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic               last_bit;
  logic               accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_comb begin
    last_bit   = (state_q == SHIFT) && (bit_cnt_q == BIT_LAST);
    load_ready = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));
    accept     = load_valid && load_ready;

    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sdo_d       = 1'b0;
    sdo_valid_d = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;

    if (accept) begin
      state_d     = SHIFT;
      shreg_d     = shift_word(load_data);
      bit_cnt_d   = '0;
      sdo_d       = head_bit(load_data);
      sdo_valid_d = 1'b1;
      sof_d       = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        SHIFT: begin
          if (!last_bit) begin
            sdo_d       = head_bit(shreg_q);
            shreg_d     = shift_word(shreg_q);
            sdo_valid_d = 1'b1;
            eof_d       = (bit_cnt_q == BIT_PENULT);
            bit_cnt_d   = bit_cnt_q + 1'b1;
          end else begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES >= 2) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = IDLE;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
    end
  end

  assign sdo       = sdo_q;
  assign sdo_valid = sdo_valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign busy      = (state_q != IDLE);

endmodule
